// File: rtl/morse_pkg.sv
// Shared morse definitions: key sequencer FSM states, symbol limits, pulse bundle.
package morse_pkg;

  localparam int MORSE_MAX_SYMBOLS = 5;
  localparam int MORSE_SYM_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESS    = 2'd1,
    ST_GAP      = 2'd2,
    ST_WAIT_REL = 2'd3
  } morse_state_e;

  typedef struct packed {
    logic dot;
    logic dash;
    logic enter;
    logic back;
  } morse_pulse_t;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchronizer plus stable-sample debouncer for the raw straight key.
module morse_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_clean
);

  logic [1:0]  sync;
  logic [15:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with key_clean
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync      <= '0;
      cnt       <= '0;
      key_clean <= 1'b0;
    end else begin
      sync <= {sync[0], key_in};
      if (sync[1] == key_clean) begin
        cnt <= '0;
      end else if (cnt >= DEBOUNCE_CYCLES - 16'd1) begin
        key_clean <= sync[1];
        cnt       <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/morse_key_sequencer.sv
// Straight-key to dot/dash/enter/back strobe sequencer for morse_encoder.
// Optional MORSE_AUTO_ENTER_EN: enter fires right after the fifth symbol.
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int                CNT_W            = 24,
  parameter logic [15:0]       DEBOUNCE_CYCLES  = 16'd50000,
  parameter logic [CNT_W-1:0]  DOT_MAX_CYCLES   = 24'd2500000,
  parameter logic [CNT_W-1:0]  BACK_HOLD_CYCLES = 24'd15000000,
  parameter logic [CNT_W-1:0]  CHAR_GAP_CYCLES  = 24'd5000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_in,
  output logic                   dot_pulse,
  output logic                   dash_pulse,
  output logic                   enter_pulse,
  output logic                   back_pulse,
  output logic [MORSE_SYM_W-1:0] sym_count,
  output logic                   key_clean
);

  localparam logic [CNT_W-1:0]       CNT_MAX = '1;
  localparam logic [MORSE_SYM_W-1:0] SYM_MAX = MORSE_SYM_W'(MORSE_MAX_SYMBOLS);

  morse_state_e           state, state_nxt;
  logic [CNT_W-1:0]       press_cnt, press_nxt, press_inc;
  logic [CNT_W-1:0]       gap_cnt, gap_nxt, gap_inc;
  logic [MORSE_SYM_W-1:0] sym_nxt;
  morse_pulse_t           pulse, pulse_nxt;

  morse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_clean(key_clean)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      press_cnt <= '0;
      gap_cnt   <= '0;
      sym_count <= '0;
      pulse     <= '0;
    end else begin
      state     <= state_nxt;
      press_cnt <= press_nxt;
      gap_cnt   <= gap_nxt;
      sym_count <= sym_nxt;
      pulse     <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    press_nxt = press_cnt;
    gap_nxt   = gap_cnt;
    sym_nxt   = sym_count;
    pulse_nxt = '0;
    press_inc = (press_cnt == CNT_MAX) ? press_cnt : press_cnt + 1'b1;
    gap_inc   = (gap_cnt == CNT_MAX) ? gap_cnt : gap_cnt + 1'b1;

    case (state)
      ST_IDLE: begin
        if (key_clean) begin
          state_nxt = ST_PRESS;
          press_nxt = '0;
        end
      end
      ST_PRESS: begin
        if (!key_clean) begin
          // a press beyond the symbol limit is still consumed, just not emitted
          if (sym_count < SYM_MAX) begin
            pulse_nxt.dot  = (press_cnt < DOT_MAX_CYCLES);
            pulse_nxt.dash = !(press_cnt < DOT_MAX_CYCLES);
            sym_nxt        = sym_count + 1'b1;
          end
          state_nxt = ST_GAP;
          gap_nxt   = '0;
        end else begin
          press_nxt = press_inc;
          if (press_inc >= BACK_HOLD_CYCLES) begin
            pulse_nxt.back = 1'b1;
            sym_nxt        = '0;
            state_nxt      = ST_WAIT_REL;
          end
        end
      end
      ST_GAP: begin
`ifdef MORSE_AUTO_ENTER_EN
        if (sym_count == SYM_MAX) begin
          pulse_nxt.enter = 1'b1;
          sym_nxt         = '0;
          state_nxt       = ST_IDLE;
        end else
`endif
        if (key_clean) begin
          state_nxt = ST_PRESS;
          press_nxt = '0;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap_inc;
          if (gap_inc >= CHAR_GAP_CYCLES) begin
            pulse_nxt.enter = 1'b1;
            sym_nxt         = '0;
            state_nxt       = ST_IDLE;
          end
        end
      end
      ST_WAIT_REL: begin
        if (!key_clean) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dot_pulse   = pulse.dot;
  assign dash_pulse  = pulse.dash;
  assign enter_pulse = pulse.enter;
  assign back_pulse  = pulse.back;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed scenarios plus random key traffic against a duration-based reference model.
module tb_morse_key_sequencer;

  localparam int DEB  = 2;
  localparam int DOT  = 8;
  localparam int BACK = 40;
  localparam int GAPC = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic       dot_pulse, dash_pulse, enter_pulse, back_pulse, key_clean;
  logic [2:0] sym_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  morse_key_sequencer #(
    .CNT_W(24), .DEBOUNCE_CYCLES(16'd2), .DOT_MAX_CYCLES(24'd8),
    .BACK_HOLD_CYCLES(24'd40), .CHAR_GAP_CYCLES(24'd20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .dot_pulse(dot_pulse), .dash_pulse(dash_pulse),
    .enter_pulse(enter_pulse), .back_pulse(back_pulse),
    .sym_count(sym_count), .key_clean(key_clean)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: hold = high samples in current press (0 = none),
  // lo_run = low samples since the last classified release (0 = no gap open).
  logic [7:0] kh;
  logic       m_clean, c, flip;
  int         m_hold, m_lo, m_syms;
  bit         m_dead, m_auto;
  logic       e_dot, e_dash, e_enter, e_back;

  always @(posedge clk) begin
    if (!rst_n) begin
      kh = '0; m_clean = 1'b0; m_hold = 0; m_lo = 0; m_syms = 0;
      m_dead = 1'b0; m_auto = 1'b0;
      e_dot = 1'b0; e_dash = 1'b0; e_enter = 1'b0; e_back = 1'b0;
    end else begin
      c = m_clean;
      e_dot = 1'b0; e_dash = 1'b0; e_enter = 1'b0; e_back = 1'b0;
      if (m_auto) begin
        e_enter = 1'b1; m_syms = 0; m_auto = 1'b0; m_lo = 0;
      end else if (m_dead) begin
        if (!c) m_dead = 1'b0;
      end else if (m_hold > 0) begin
        if (c) begin
          m_hold++;
          if (m_hold == BACK + 1) begin
            e_back = 1'b1; m_syms = 0; m_hold = 0; m_dead = 1'b1;
          end
        end else begin
          if (m_syms < 5) begin
            m_syms++;
            if (m_hold <= DOT) e_dot = 1'b1; else e_dash = 1'b1;
`ifdef MORSE_AUTO_ENTER_EN
            if (m_syms == 5) m_auto = 1'b1;
`endif
          end
          m_hold = 0; m_lo = 1;
        end
      end else if (m_lo > 0) begin
        if (c) begin
          m_hold = 1; m_lo = 0;
        end else begin
          m_lo++;
          if (m_lo == GAPC + 1) begin
            e_enter = 1'b1; m_syms = 0; m_lo = 0;
          end
        end
      end else if (c) begin
        m_hold = 1;
      end
      // level accepted once the last DEB synchronized samples all disagree with it
      flip = 1'b1;
      for (int i = 1; i <= DEB; i++) if (kh[i] == m_clean) flip = 1'b0;
      if (flip) m_clean = ~m_clean;
      kh = {kh[6:0], key_in};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dot",       dot_pulse,   e_dot);
      chk("dash",      dash_pulse,  e_dash);
      chk("enter",     enter_pulse, e_enter);
      chk("back",      back_pulse,  e_back);
      chk("sym_count", sym_count,   8'(m_syms));
      chk("key_clean", key_clean,   m_clean);
      chk("onehot",    $onehot0({dot_pulse, dash_pulse, enter_pulse, back_pulse}), 1'b1);
    end
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      key_in = v;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    // reset held while key toggles
    for (int i = 0; i < 10; i++) drive(i[0], 1);
    rst_n = 1'b1;
    drive(0, 4);
    // dot, dash, then enter after the gap
    drive(1, 4);  drive(0, 5);
    drive(1, 12); drive(0, 25);
    // single-cycle bounces
    for (int i = 0; i < 5; i++) begin drive(1, 1); drive(0, 3); end
    drive(0, 5);
    // dot then long hold -> back
    drive(1, 4);  drive(0, 5);
    drive(1, 50); drive(0, 30);
    // six dots in one character
    for (int i = 0; i < 6; i++) begin drive(1, 4); drive(0, 5); end
    drive(0, 30);
    // reset in the middle of a press
    drive(1, 9);
    rst_n = 1'b0;
    drive(0, 3);
    rst_n = 1'b1;
    drive(0, 30);
    // random traffic including glitches
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) drive(1, 1);
      else drive(1, $urandom_range(1, 50));
      drive(0, $urandom_range(1, 30));
    end
    drive(0, 40);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
